// File: rtl/microcode_pkg.sv
// Shared types and constants for the microprogrammed control store.
package microcode_pkg;

  typedef logic [3:0] uaddr_t;

  typedef enum logic [2:0] {
    SEQ   = 3'd0,
    DISP1 = 3'd1,
    DISP2 = 3'd2,
    FETCH = 3'd3,
    GOTO7 = 3'd4,
    HOLD  = 3'd5
  } addr_ctl_e;

  localparam uaddr_t S_FETCH    = 4'd0;
  localparam uaddr_t S_DECODE   = 4'd1;
  localparam uaddr_t S_MEMADR   = 4'd2;
  localparam uaddr_t S_MEMREAD  = 4'd3;
  localparam uaddr_t S_MEMWB    = 4'd4;
  localparam uaddr_t S_MEMWRITE = 4'd5;
  localparam uaddr_t S_EXECR    = 4'd6;
  localparam uaddr_t S_ALUWB    = 4'd7;
  localparam uaddr_t S_EXECI    = 4'd8;
  localparam uaddr_t S_JAL      = 4'd9;
  localparam uaddr_t S_BEQ      = 4'd10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_word_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;

  function automatic logic op_legal(logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_JAL, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational control-store lookup: micro-address to raw control word and next-address select.
module microcode_rom
  import microcode_pkg::*;
(
  input  uaddr_t     addr_i,
  output ctrl_word_t ctrl_o,
  output addr_ctl_e  addr_ctl_o,
  output logic       is_mem_o,
  output logic       valid_o
);

  always_comb begin
    ctrl_o     = '0;
    addr_ctl_o = FETCH;
    is_mem_o   = 1'b0;
    valid_o    = 1'b1;
    case (addr_i)
      S_FETCH: begin
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.alu_src_b  = 2'b10;
        ctrl_o.result_src = 2'b10;
        addr_ctl_o        = SEQ;
        is_mem_o          = 1'b1;
      end
      S_DECODE:  addr_ctl_o = DISP1;
      S_MEMADR:  addr_ctl_o = DISP2;
      S_MEMREAD: begin
        addr_ctl_o = SEQ;
        is_mem_o   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = 2'b01;
        addr_ctl_o        = FETCH;
      end
      S_MEMWRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.adr_src   = 1'b1;
        addr_ctl_o       = FETCH;
        is_mem_o         = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_op = 2'b10;
        addr_ctl_o    = SEQ;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        addr_ctl_o       = FETCH;
      end
      S_EXECI: begin
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = 2'b10;
        addr_ctl_o       = GOTO7;
      end
      S_JAL:     addr_ctl_o = GOTO7;
      S_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = 2'b01;
        addr_ctl_o    = FETCH;
      end
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/microcode_store.sv
// Control store with memory wait/timeout handling, illegal-state trapping and a retire counter.
module microcode_store
  import microcode_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       currAddr,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  input  logic             err_clr,
  output logic [2:0]       addrCtl,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             Branch,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             bus_err,
  output logic             ill_uaddr,
  output logic             ill_op,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  ctrl_word_t rom_ctrl, ctrl;
  addr_ctl_e  rom_ac, ac;
  logic       rom_mem, rom_valid;
  logic       op_trap, waiting, timeout, retire;

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             ill_uaddr_q, ill_uaddr_d;
  logic             ill_op_q, ill_op_d;

  microcode_rom u_rom (
    .addr_i     (currAddr),
    .ctrl_o     (rom_ctrl),
    .addr_ctl_o (rom_ac),
    .is_mem_o   (rom_mem),
    .valid_o    (rom_valid)
  );

  // MemAdr only dispatches loads and stores; anything else reaching it is a trap.
  assign op_trap = ((currAddr == S_DECODE) && !op_legal(op)) ||
                   ((currAddr == S_MEMADR) && (op != OP_LW) && (op != OP_SW));
  assign waiting = rom_valid && rom_mem && !mem_ready;
  assign timeout = waiting && (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1));

  always_comb begin
    ctrl       = rom_ctrl;
    ac         = rom_ac;
    mem_req    = rom_valid && rom_mem;
    wait_cnt_d = '0;
    retire     = 1'b0;
    if (!rom_valid || op_trap || timeout) begin
      ctrl    = '0;
      ac      = FETCH;
      mem_req = 1'b0;
    end else if (waiting) begin
      // MemWrite stays high through the stall so the store is held on the bus.
      ac             = HOLD;
      ctrl.pc_write  = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.reg_write = 1'b0;
      wait_cnt_d     = wait_cnt_q + WaitW'(1);
    end else begin
      retire = (rom_ac == FETCH);
    end
  end

  always_comb begin
    bus_err_d   = timeout | (bus_err_q & ~err_clr);
    ill_uaddr_d = ~rom_valid | (ill_uaddr_q & ~err_clr);
    ill_op_d    = (rom_valid & op_trap) | (ill_op_q & ~err_clr);
    instr_cnt_d = instr_cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q  <= '0;
      instr_cnt_q <= '0;
      bus_err_q   <= 1'b0;
      ill_uaddr_q <= 1'b0;
      ill_op_q    <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      bus_err_q   <= bus_err_d;
      ill_uaddr_q <= ill_uaddr_d;
      ill_op_q    <= ill_op_d;
    end
  end

  assign addrCtl   = ac;
  assign PCWrite   = ctrl.pc_write;
  assign IRWrite   = ctrl.ir_write;
  assign RegWrite  = ctrl.reg_write;
  assign MemWrite  = ctrl.mem_write;
  assign Branch    = ctrl.branch;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign bus_err   = bus_err_q;
  assign ill_uaddr = ill_uaddr_q;
  assign ill_op    = ill_op_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_microcode_store.sv
// Bench for microcode_store: vector table, hand sequences and random stimulus against a model.
module tb_microcode_store;

  localparam int TO = 8;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011, LW = 7'b0000011, SW = 7'b0100011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] currAddr = 4'd0;
  logic [6:0] op = R;
  logic mem_ready = 1'b1, err_clr = 1'b0;

  logic [2:0] addrCtl, w4_addrCtl;
  logic mem_req, PCWrite, IRWrite, RegWrite, MemWrite, Branch, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic bus_err, ill_uaddr, ill_op;
  logic [31:0] instr_cnt;
  logic w4_mem_req, w4_PCWrite, w4_IRWrite, w4_RegWrite, w4_MemWrite, w4_Branch, w4_AdrSrc;
  logic [1:0] w4_ResultSrc, w4_ALUSrcA, w4_ALUSrcB, w4_ALUOp;
  logic w4_bus_err, w4_ill_uaddr, w4_ill_op;
  logic [3:0] w4_instr_cnt;

  logic [13:0] dut_str;
  assign dut_str = {PCWrite, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  always #5 clk = ~clk;

  microcode_store #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .currAddr(currAddr), .op(op), .mem_ready(mem_ready),
    .err_clr(err_clr), .addrCtl(addrCtl), .mem_req(mem_req), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .bus_err(bus_err), .ill_uaddr(ill_uaddr), .ill_op(ill_op),
    .instr_cnt(instr_cnt)
  );

  microcode_store #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .currAddr(currAddr), .op(op), .mem_ready(mem_ready),
    .err_clr(err_clr), .addrCtl(w4_addrCtl), .mem_req(w4_mem_req), .PCWrite(w4_PCWrite),
    .IRWrite(w4_IRWrite), .RegWrite(w4_RegWrite), .MemWrite(w4_MemWrite),
    .Branch(w4_Branch), .AdrSrc(w4_AdrSrc), .ResultSrc(w4_ResultSrc),
    .ALUSrcA(w4_ALUSrcA), .ALUSrcB(w4_ALUSrcB), .ALUOp(w4_ALUOp), .bus_err(w4_bus_err),
    .ill_uaddr(w4_ill_uaddr), .ill_op(w4_ill_op), .instr_cnt(w4_instr_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  int          m_wait;
  bit          m_bus, m_uad, m_iop;
  int unsigned m_cnt;
  logic [2:0]  rom_ac  [16];
  logic [13:0] rom_str [16];
  logic [6:0]  legal_ops [6];

  typedef struct {
    logic [3:0]  a;
    logic [6:0]  o;
    logic        r;
    logic        c;
    logic [2:0]  ac;
    logic [13:0] st;
    logic        rq;
  } vec_t;
  vec_t tab[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] a, input logic [6:0] o, input logic r, input logic c,
                     input logic [2:0] ac, input logic [13:0] st, input logic rq);
    vec_t v;
    v.a = a; v.o = o; v.r = r; v.c = c; v.ac = ac; v.st = st; v.rq = rq;
    tab.push_back(v);
  endtask

  // Drive one cycle, compare everything against the model, then advance the model.
  task automatic step(input logic [3:0] a, input logic [6:0] o, input logic r, input logic c);
    logic [2:0] ac;
    logic [13:0] st;
    logic rq, sb, su, so, rt, is_mem, trap, legal;
    int nw;
    @(posedge clk);
    #1;
    currAddr = a; op = o; mem_ready = r; err_clr = c;
    @(negedge clk);
    is_mem = (a == 4'd0) || (a == 4'd3) || (a == 4'd5);
    legal  = o inside {R, I, JAL, BEQ, LW, SW};
    trap   = (a >= 4'd11) || (a == 4'd1 && !legal) || (a == 4'd2 && !(o == LW || o == SW));
    sb = 0; su = 0; so = 0; rt = 0; nw = 0;
    if (trap) begin
      ac = 3'd3; st = '0; rq = 0;
      su = (a >= 4'd11); so = !su;
    end else if (is_mem && !r && m_wait == TO - 1) begin
      ac = 3'd3; st = '0; rq = 0; sb = 1;
    end else if (is_mem && !r) begin
      ac = 3'd5; st = rom_str[a] & 14'b00011111111111; rq = 1; nw = m_wait + 1;
    end else begin
      ac = rom_ac[a]; st = rom_str[a]; rq = is_mem; rt = (rom_ac[a] == 3'd3);
    end
    chk("addrCtl", 64'(addrCtl), 64'(ac));
    chk("strobes", 64'(dut_str), 64'(st));
    chk("mem_req", 64'(mem_req), 64'(rq));
    chk("bus_err", 64'(bus_err), 64'(m_bus));
    chk("ill_uaddr", 64'(ill_uaddr), 64'(m_uad));
    chk("ill_op", 64'(ill_op), 64'(m_iop));
    chk("instr_cnt", 64'(instr_cnt), 64'(m_cnt));
    chk("instr_cnt_w4", 64'(w4_instr_cnt), 64'(m_cnt[3:0]));
    m_bus  = sb | (m_bus & !c);
    m_uad  = su | (m_uad & !c);
    m_iop  = so | (m_iop & !c);
    m_cnt  = m_cnt + 32'(rt);
    m_wait = nw;
  endtask

  task automatic model_reset();
    m_wait = 0; m_bus = 0; m_uad = 0; m_iop = 0; m_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] ra;
    logic [6:0] ro;
    for (int i = 0; i < 16; i++) begin
      rom_ac[i] = 3'd3; rom_str[i] = '0;
    end
    rom_ac[0] = 3'd0; rom_str[0] = 14'b110000_10_00_10_00;
    rom_ac[1] = 3'd1;
    rom_ac[2] = 3'd2;
    rom_ac[3] = 3'd0;
    rom_ac[4] = 3'd3; rom_str[4] = 14'b001000_01_00_00_00;
    rom_ac[5] = 3'd3; rom_str[5] = 14'b000101_00_00_00_00;
    rom_ac[6] = 3'd0; rom_str[6] = 14'b000000_00_00_00_10;
    rom_ac[7] = 3'd3; rom_str[7] = 14'b001000_00_00_00_00;
    rom_ac[8] = 3'd4; rom_str[8] = 14'b000000_00_00_01_10;
    rom_ac[9] = 3'd4;
    rom_ac[10] = 3'd3; rom_str[10] = 14'b000010_00_00_00_01;
    legal_ops[0] = R; legal_ops[1] = I; legal_ops[2] = JAL;
    legal_ops[3] = BEQ; legal_ops[4] = LW; legal_ops[5] = SW;

    add(0, R, 1, 0, 3'd0, 14'b110000_10_00_10_00, 1);
    add(1, R, 1, 0, 3'd1, 14'b0, 0);
    add(6, R, 1, 0, 3'd0, 14'b000000_00_00_00_10, 0);
    add(7, R, 1, 0, 3'd3, 14'b001000_00_00_00_00, 0);
    add(0, LW, 1, 0, 3'd0, 14'b110000_10_00_10_00, 1);
    add(1, LW, 1, 0, 3'd1, 14'b0, 0);
    add(2, LW, 1, 0, 3'd2, 14'b0, 0);
    add(3, LW, 0, 0, 3'd5, 14'b0, 1);
    add(3, LW, 0, 0, 3'd5, 14'b0, 1);
    add(3, LW, 0, 0, 3'd5, 14'b0, 1);
    add(3, LW, 1, 0, 3'd0, 14'b0, 1);
    add(4, LW, 1, 0, 3'd3, 14'b001000_01_00_00_00, 0);
    add(2, SW, 1, 0, 3'd2, 14'b0, 0);
    add(5, SW, 0, 0, 3'd5, 14'b000101_00_00_00_00, 1);
    add(5, SW, 1, 0, 3'd3, 14'b000101_00_00_00_00, 1);
    add(10, BEQ, 1, 0, 3'd3, 14'b000010_00_00_00_01, 0);
    add(8, I, 1, 0, 3'd4, 14'b000000_00_00_01_10, 0);
    add(9, JAL, 1, 0, 3'd4, 14'b0, 0);
    add(0, R, 0, 0, 3'd5, 14'b000000_10_00_10_00, 1);
    add(0, R, 1, 0, 3'd0, 14'b110000_10_00_10_00, 1);
    add(12, R, 0, 1, 3'd3, 14'b0, 0);
    add(0, R, 1, 1, 3'd0, 14'b110000_10_00_10_00, 1);
    add(1, 7'b1111111, 1, 0, 3'd3, 14'b0, 0);
    add(2, R, 1, 0, 3'd3, 14'b0, 0);
    add(11, R, 1, 0, 3'd3, 14'b0, 0);

    // Reset with Fetch presented.
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    chk("rst_ill_uaddr", 64'(ill_uaddr), 64'd0);
    chk("rst_ill_op", 64'(ill_op), 64'd0);
    chk("rst_instr_cnt", 64'(instr_cnt), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_IRWrite", 64'(IRWrite), 64'd1);
    chk("rel_PCWrite", 64'(PCWrite), 64'd1);
    chk("rel_addrCtl", 64'(addrCtl), 64'd0);

    foreach (tab[i]) begin
      step(tab[i].a, tab[i].o, tab[i].r, tab[i].c);
      chk($sformatf("tab%0d_addrCtl", i), 64'(addrCtl), 64'(tab[i].ac));
      chk($sformatf("tab%0d_strobes", i), 64'(dut_str), 64'(tab[i].st));
      chk($sformatf("tab%0d_mem_req", i), 64'(mem_req), 64'(tab[i].rq));
    end
    step(0, R, 1, 0);
    chk("rtype_retired", 64'(instr_cnt), 64'd4);
    chk("set_wins_cleared_later", 64'(ill_uaddr), 64'd1);

    // Set beats clear in the same cycle.
    step(0, R, 1, 1);
    step(0, R, 1, 0);
    chk("uaddr_cleared", 64'(ill_uaddr), 64'd0);
    step(13, R, 1, 1);
    step(0, R, 1, 0);
    chk("uaddr_set_wins", 64'(ill_uaddr), 64'd1);

    // Reset in the middle of a memory wait; the wait count must restart.
    repeat (4) step(3, LW, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_flags", 64'({bus_err, ill_uaddr, ill_op}), 64'd0);
    chk("async_rst_cnt", 64'(instr_cnt), 64'd0);
    model_reset();
    currAddr = 4'd0; op = R; mem_ready = 1'b1; err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Store that never completes times out on the eighth cycle.
    for (int i = 0; i < TO; i++) begin
      step(5, SW, 0, 0);
      chk($sformatf("to_addrCtl_%0d", i), 64'(addrCtl), (i < TO - 1) ? 64'd5 : 64'd3);
      chk($sformatf("to_MemWrite_%0d", i), 64'(MemWrite), (i < TO - 1) ? 64'd1 : 64'd0);
    end
    step(0, R, 1, 0);
    chk("bus_err_set", 64'(bus_err), 64'd1);
    repeat (3) step(0, R, 1, 0);
    chk("bus_err_sticky", 64'(bus_err), 64'd1);
    step(0, R, 1, 1);
    step(0, R, 1, 0);
    chk("bus_err_cleared", 64'(bus_err), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 15));
      ro = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 5)] : 7'($urandom);
      step(ra, ro, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
